// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module ex_div_unit #(
    parameter int XLEN           = 32,
    parameter bit SPECIAL_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, result_q, result_d;
    logic [4:0] cnt_q, cnt_d, tag_q, tag_d, rd_q, rd_d;
    logic sq_q, sq_d, sr_q, sr_d, sel_q, sel_d, busy_q, busy_d, done_q, done_d;
    logic sgn, accept, b_zero, ovf, bypass;
    logic [XLEN:0] shifted, trial;
    logic [XLEN-1:0] abs_a, abs_b, quo_fix, rem_fix;
    assign sgn     = ~funct3[0];
    assign accept  = start & ~flush & funct3[2] & (state_q == IDLE || state_q == DONE);
    assign b_zero  = op_b == '0;
    assign ovf     = sgn & (op_a == MIN) & (op_b == '1);
    assign bypass  = SPECIAL_BYPASS & (b_zero | ovf);
    assign abs_a   = (sgn & op_a[XLEN-1]) ? -op_a : op_a;
    assign abs_b   = (sgn & op_b[XLEN-1]) ? -op_b : op_b;
    assign shifted = {1'b0, rem_q, quo_q[XLEN-1]} >> 0;
    assign trial   = shifted - {1'b0, div_q};
    // A zero divisor leaves an all-ones quotient that must not be negated.
    assign quo_fix = (sq_q && div_q != '0) ? -quo_q : quo_q;
    assign rem_fix = sr_q ? -rem_q : rem_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            rd_q     <= '0;
            sq_q     <= 1'b0;
            sr_q     <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            rd_q     <= rd_d;
            sq_q     <= sq_d;
            sr_q     <= sr_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = IDLE;
        else if (accept)
            state_d = bypass ? DONE : CALC;
        else
            state_d = state_q == CALC ? (cnt_q == 5'd31 ? FIX : CALC) :
                      state_q == FIX  ? DONE : IDLE;
    end
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        rd_d     = rd_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        sel_d    = sel_q;
        if (accept) begin
            rem_d = '0;
            quo_d = abs_a;
            div_d = abs_b;
            cnt_d = '0;
            sq_d  = sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            sr_d  = sgn & op_a[XLEN-1];
            sel_d = funct3[1];
            tag_d = rd_in;
            if (bypass) begin
                result_d = b_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN);
                rd_d     = rd_in;
            end
        end else if (!flush && state_q == CALC) begin
            rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
            cnt_d = cnt_q + 5'd1;
        end else if (!flush && state_q == FIX) begin
            result_d = sel_q ? rem_fix : quo_fix;
            rd_d     = tag_q;
        end
    end
    always_comb begin
        busy_d = state_d == CALC || state_d == FIX;
        done_d = state_d == DONE;
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, instantiated in the EX stage of pipeline_cpu.
- EX launches an operation with a one-cycle start pulse. While busy is high, the hazard logic holds IF/ID/EX.
- The result and destination register tag are consumed by the EX/MEM register in the cycle done is high.
- Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- SPECIAL_BYPASS, 1, when 1, divide-by-zero and overflow complete in 1 cycle; when 0, they run the full iteration and are corrected in FIX.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces IDLE
- start  input  1  one-cycle launch request from EX
- funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; sampled with start
- op_a  input  XLEN  dividend (rs1); sampled with start
- op_b  input  XLEN  divisor (rs2); sampled with start
- rd_in  input  5  destination register; sampled with start
- flush  input  1  pipeline flush; aborts any operation
- busy  output  1  high while an accepted operation is in CALC or FIX
- done  output  1  one-cycle pulse; result and rd_out valid
- result  output  XLEN  quotient or remainder per funct3
- rd_out  output  5  registered copy of rd_in

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, rd_out=0; iteration counter=0.
- States: IDLE, CALC, FIX, DONE. busy=1 in CALC and FIX only. done=1 in DONE only. All outputs are registered.
- Acceptance: start is accepted on an edge when state is IDLE or DONE and flush=0. start in CALC or FIX is ignored; no queuing.
- funct3[2]=0 is illegal: start is ignored and the state does not change.
- Setup on the accept edge:
  - Latch sign_q = signed & (a[31]^b[31]) and sign_r = signed & a[31].
  - Latch |a| and |b| (unsigned ops use raw values), plus rd_in and funct3.
  - Clear the remainder register and counter.
  - Go to CALC, unless a bypass case applies.
- Bypass cases (SPECIAL_BYPASS=1), accept edge goes directly to DONE:
  - b==0: quotient=0xFFFFFFFF for both DIV and DIVU; remainder=a.
  - Signed ops with a==0x80000000 and b==0xFFFFFFFF: quotient=0x80000000; remainder=0.
- CALC, one restoring step per edge:
  - {rem,quo} shifted left 1; trial = rem − |b|.
  - If trial ≥ 0: rem=trial and quo[0]=1.
  - The counter increments. On the 32nd CALC edge (counter 31), go to FIX.
- FIX, one edge:
  - Negate quo if sign_q; negate rem if sign_r.
  - Select quo (funct3[1]=0) or rem (funct3[1]=1) into result; go to DONE.
- Non-bypass latency: done is high in the cycle after the 34th edge counted from the accept edge (1 accept + 32 CALC + 1 FIX). busy is high for exactly 33 cycles.
- DONE: lasts exactly one cycle.
  - Next state is IDLE, or CALC/DONE if a new start is accepted.
  - result and rd_out hold their values until the next completion or reset.
- flush: from any state, the next edge goes to IDLE with busy=0, done=0, and no completion is produced. flush wins over a simultaneous start.
- Reset asserted mid-operation aborts immediately, with no done pulse.
- Arithmetic: internal remainder width is XLEN+1 to hold the trial sign. Negation is two's complement modulo 2^32. Quotient and remainder satisfy a = q*b + r, with r taking the sign of the dividend.

Test Plan:
- DIVU a=100, b=7 -> done on the 34th cycle after accept, result=0x0000000E, rd_out=rd_in; REMU same operands -> 0x00000002.
- DIV a=0xFFFFFFF9 (−7), b=2 -> 0xFFFFFFFD (−3); REM -> 0xFFFFFFFF (−1); REM a=7, b=0xFFFFFFFE -> 0x00000001.
- DIVU a=0x12345678, b=0 -> done 1 cycle after accept, result=0xFFFFFFFF, busy never high; REMU -> 0x12345678.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 1 cycle; REM -> 0x00000000.
- Start DIVU 1000/3 and pulse flush on the 10th busy cycle -> busy=0 next cycle, no done within 40 cycles. Then start 9/3 -> result=3 with normal latency.
- Start, then raise start again with new operands on the 5th busy cycle -> ignored, first result correct. Assert reset mid-CALC -> busy=0 and done=0 immediately with no clock edge.
